// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset main control FSM.
// op_supported() accepts opcode 000010 only when CTRL_JUMP_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_word_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef CTRL_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

    // States that wait on the memory handshake and feed the stall counter.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational Moore decode of the control state into the datapath control word.
// The JUMP decode exists only when CTRL_JUMP_EN is defined.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // PC and IR load only on the cycle the fetch actually completes.
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_SEXT_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
`ifdef CTRL_JUMP_EN
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS-subset main control FSM with memory stall counter and optional timeout.
// Define CTRL_JUMP_EN to build the J instruction path; otherwise opcode 000010 is illegal.
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    localparam bit TIMEOUT_EN = (WAIT_LIMIT != 0);
    // Timeout fires during the WAIT_LIMIT-th stall cycle, i.e. when the count of earlier stalls is WAIT_LIMIT-1.
    localparam logic [CNT_W-1:0] LAST_STALL = TIMEOUT_EN ? CNT_W'(WAIT_LIMIT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] stall_cnt;
    logic             stalled;
    logic             timeout;
    ctrl_word_t       ctrl;

    assign stalled    = is_mem_wait(state) && !mem_ready;
    assign timeout    = TIMEOUT_EN && stalled && (stall_cnt == LAST_STALL);
    assign illegal_op = (state == S_DECODE) && !op_supported(opcode);
    assign bus_error  = timeout;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stall_cnt <= '0;
        end else if (timeout) begin
            state     <= S_IDLE;
            stall_cnt <= '0;
        end else begin
            // Saturate so an unlimited wait never wraps the counter.
            if (stalled)
                stall_cnt <= (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
            else
                stall_cnt <= '0;

            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state <= S_EXEC;
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_BEQ:       state <= S_BRANCH;
`ifdef CTRL_JUMP_EN
                        OP_J:         state <= S_JUMP;
`endif
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
                S_MEM_WB:   state <= S_FETCH;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_EXEC:     state <= S_R_WB;
                S_R_WB:     state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
`ifdef CTRL_JUMP_EN
                S_JUMP:     state <= S_FETCH;
`endif
                default:    state <= S_IDLE;
            endcase
        end
    end

    ctrl_output_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm (WAIT_LIMIT=4): per-instruction cycle traces built from the instruction rules.
// Expectations follow CTRL_JUMP_EN the same way the design does.
module tb_main_control_fsm;

    localparam int LIMIT = 4;
`ifdef CTRL_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, bus_error;
    logic [3:0] state_dbg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    main_control_fsm #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .bus_error     (bus_error),
        .state_dbg     (state_dbg)
    );

    typedef struct {
        int         st;
        bit         mr;
        bit         ill;
        bit         berr;
        logic [5:0] op;
    } cyc_t;

    cyc_t plan[$];

    function automatic logic [15:0] obs_ctrl();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    // Control word expected in each state number, straight from the state table.
    function automatic logic [15:0] exp_ctrl(int st, bit mr);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, ao, ps;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mrd = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iod = 1; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps};
    endfunction

    function automatic bit legal(logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (JUMP_EN && op == 6'b000010);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int st, bit mr, bit ill, bit berr, logic [5:0] op);
        cyc_t c;
        c.st = st; c.mr = mr; c.ill = ill; c.berr = berr; c.op = op;
        plan.push_back(c);
    endtask

    // A memory wait of 'stalls' low cycles; LIMIT or more low cycles end in bus_error and IDLE.
    task automatic mem_phase(int st, int stalls, logic [5:0] op, output bit aborted);
        int n;
        n = (stalls < LIMIT) ? stalls : LIMIT;
        for (int i = 0; i < n; i++)
            push(st, 1'b0, 1'b0, (stalls >= LIMIT) && (i == LIMIT - 1), op);
        if (stalls >= LIMIT) begin
            push(0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, op);
            aborted = 1'b1;
        end else begin
            push(st, 1'b1, 1'b0, 1'b0, op);
            aborted = 1'b0;
        end
    endtask

    task automatic plan_instr(logic [5:0] op, int fstall, int mstall);
        bit ab;
        mem_phase(1, fstall, op, ab);
        if (!ab) begin
            push(2, 1'($urandom_range(0, 1)), !legal(op), 1'b0, op);
            if (legal(op)) begin
                case (op)
                    6'b000000: begin
                        push(7, 1'($urandom_range(0, 1)), 0, 0, op);
                        push(8, 1'($urandom_range(0, 1)), 0, 0, op);
                    end
                    6'b100011: begin
                        push(3, 1'($urandom_range(0, 1)), 0, 0, op);
                        mem_phase(4, mstall, op, ab);
                        if (!ab) push(5, 1'($urandom_range(0, 1)), 0, 0, op);
                    end
                    6'b101011: begin
                        push(3, 1'($urandom_range(0, 1)), 0, 0, op);
                        mem_phase(6, mstall, op, ab);
                    end
                    6'b000100: push(9, 1'($urandom_range(0, 1)), 0, 0, op);
                    default:   push(10, 1'($urandom_range(0, 1)), 0, 0, op);
                endcase
            end
        end
    endtask

    task automatic run_plan(string name);
        cyc_t c;
        int cyc;
        cyc = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            opcode    = c.op;
            mem_ready = c.mr;
            @(negedge clk);
            chk($sformatf("%s.c%0d.state", name, cyc), 32'(state_dbg), 32'(c.st));
            chk($sformatf("%s.c%0d.ctrl", name, cyc), 32'(obs_ctrl()), 32'(exp_ctrl(c.st, c.mr)));
            chk($sformatf("%s.c%0d.illegal", name, cyc), 32'(illegal_op), 32'(c.ill));
            chk($sformatf("%s.c%0d.buserr", name, cyc), 32'(bus_error), 32'(c.berr));
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    logic [5:0] optab [5];

    initial begin
        optab[0] = 6'b000000; optab[1] = 6'b100011; optab[2] = 6'b101011;
        optab[3] = 6'b000100; optab[4] = 6'b000010;

        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
        repeat (3) @(negedge clk);
        chk("reset.state", 32'(state_dbg), 32'd0);
        chk("reset.ctrl", 32'(obs_ctrl()), 32'd0);
        chk("reset.illegal", 32'(illegal_op), 32'd0);
        chk("reset.buserr", 32'(bus_error), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        plan_instr(6'b000000, 0, 0); run_plan("rtype");
        plan_instr(6'b100011, 0, 3); run_plan("lw_stall3");
        plan_instr(6'b101011, 0, 0); run_plan("sw");
        plan_instr(6'b000100, 0, 0); run_plan("beq");
        plan_instr(6'b111111, 0, 0); run_plan("illegal");
        plan_instr(6'b000010, 0, 0); run_plan("jump");
        plan_instr(6'b101011, 2, 4); run_plan("sw_timeout");
        plan_instr(6'b100011, 5, 0); run_plan("fetch_timeout");
        plan_instr(6'b100011, 1, 6); run_plan("lw_timeout");

        for (int k = 0; k < 80; k++) begin
            logic [5:0] op;
            int sel, fs, ms;
            sel = $urandom_range(0, 5);
            op  = (sel == 5) ? 6'($urandom) : optab[sel];
            fs  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            ms  = $urandom_range(0, 5);
            plan_instr(op, fs, ms);
            run_plan($sformatf("rnd%0d", k));
        end

        // Drive into a stalled MEM_WR, then assert reset between clock edges.
        opcode = 6'b101011; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        chk("async.pre_state", 32'(state_dbg), 32'd6);
        chk("async.pre_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async.mem_write", 32'(mem_write), 32'd0);
        chk("async.state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        chk("async.held_ctrl", 32'(obs_ctrl()), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("async.release_state", 32'(state_dbg), 32'd1);
        chk("async.release_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(1, 1'b1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
